// File: rtl/pulse_cmd_sender.sv
`default_nettype none
// ============================================================================
// Module      : pulse_cmd_sender
// Description : Sends a 5-byte command frame (4 payload bytes LSB first, then
//               the control byte) through a byte UART, then waits for the
//               8-bit checksum echo and reports ok / mismatch / timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module pulse_cmd_sender #(
    parameter logic [31:0] ACK_TIMEOUT = 32'd2400000,
    parameter int unsigned NBYTES_DATA = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_ctrl,
    input  logic [31:0] cmd_data,
    output logic        transmit,
    output logic [7:0]  tx_byte,
    input  logic        is_transmitting,
    input  logic        received,
    input  logic [7:0]  rx_byte,
    input  logic        recv_error,
    output logic        resp_valid,
    output logic        resp_ok,
    output logic        resp_timeout,
    output logic [7:0]  resp_byte
);

    localparam logic [2:0] c_ST_IDLE       = 3'd0;
    localparam logic [2:0] c_ST_LOAD       = 3'd1;
    localparam logic [2:0] c_ST_SEND       = 3'd2;
    localparam logic [2:0] c_ST_WAIT_START = 3'd3;
    localparam logic [2:0] c_ST_WAIT_END   = 3'd4;
    localparam logic [2:0] c_ST_WAIT_ACK   = 3'd5;
    localparam logic [2:0] c_ST_REPORT     = 3'd6;

    // Index of the control byte, which is the last byte of the frame.
    localparam logic [2:0] c_LAST_IDX = 3'(NBYTES_DATA);

    logic [2:0]  r_state;
    logic [2:0]  w_state_nxt;
    logic [7:0]  r_ctrl;
    logic [31:0] r_data;
    logic [7:0]  r_expected;
    logic [2:0]  r_idx;
    logic [31:0] r_cnt;
    logic        r_transmit;
    logic [7:0]  r_tx_byte;
    logic        r_resp_ok;
    logic        r_resp_timeout;
    logic [7:0]  r_resp_byte;

    logic [7:0]  w_cmd_sum;
    logic [7:0]  w_cur_byte;
    logic        w_timeout_hit;

    // Checksum of the incoming payload; 8-bit adds drop the carries.
    assign w_cmd_sum = cmd_data[7:0] + cmd_data[15:8] + cmd_data[23:16] + cmd_data[31:24];

    assign w_timeout_hit = (r_cnt == (ACK_TIMEOUT - 32'd1));

    // Select the frame byte addressed by the byte index.
    always_comb begin
        w_cur_byte = r_ctrl;
        case (r_idx)
            3'd0:    w_cur_byte = r_data[7:0];
            3'd1:    w_cur_byte = r_data[15:8];
            3'd2:    w_cur_byte = r_data[23:16];
            3'd3:    w_cur_byte = r_data[31:24];
            default: w_cur_byte = r_ctrl;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; an error strobe, a byte or the timeout all end WAIT_ACK.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:       if (cmd_valid) w_state_nxt = c_ST_LOAD;
            c_ST_LOAD:       w_state_nxt = c_ST_SEND;
            c_ST_SEND:       if (!is_transmitting) w_state_nxt = c_ST_WAIT_START;
            c_ST_WAIT_START: if (is_transmitting) w_state_nxt = c_ST_WAIT_END;
            c_ST_WAIT_END: begin
                if (!is_transmitting) begin
                    w_state_nxt = (r_idx == c_LAST_IDX) ? c_ST_WAIT_ACK : c_ST_LOAD;
                end
            end
            c_ST_WAIT_ACK: begin
                if (recv_error || received || w_timeout_hit) w_state_nxt = c_ST_REPORT;
            end
            c_ST_REPORT:     w_state_nxt = c_ST_IDLE;
            default:         w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Datapath: command latch, byte sequencing, transmit strobe, ack capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ctrl         <= 8'd0;
            r_data         <= 32'd0;
            r_expected     <= 8'd0;
            r_idx          <= 3'd0;
            r_cnt          <= 32'd0;
            r_transmit     <= 1'b0;
            r_tx_byte      <= 8'd0;
            r_resp_ok      <= 1'b0;
            r_resp_timeout <= 1'b0;
            r_resp_byte    <= 8'd0;
        end else begin
            r_transmit <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (cmd_valid) begin
                        r_ctrl     <= cmd_ctrl;
                        r_data     <= cmd_data;
                        r_expected <= w_cmd_sum;
                        r_idx      <= 3'd0;
                    end
                end
                c_ST_LOAD: r_tx_byte <= w_cur_byte;
                c_ST_SEND: begin
                    if (!is_transmitting) r_transmit <= 1'b1;
                end
                c_ST_WAIT_END: begin
                    if (!is_transmitting) begin
                        if (r_idx == c_LAST_IDX) begin
                            r_cnt <= 32'd0;
                        end else begin
                            r_idx <= r_idx + 3'd1;
                        end
                    end
                end
                c_ST_WAIT_ACK: begin
                    if (recv_error) begin
                        r_resp_ok      <= 1'b0;
                        r_resp_timeout <= 1'b0;
                        r_resp_byte    <= rx_byte;
                    end else if (received) begin
                        r_resp_ok      <= (rx_byte == r_expected);
                        r_resp_timeout <= 1'b0;
                        r_resp_byte    <= rx_byte;
                    end else if (w_timeout_hit) begin
                        r_resp_ok      <= 1'b0;
                        r_resp_timeout <= 1'b1;
                        r_resp_byte    <= 8'd0;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign cmd_ready    = (r_state == c_ST_IDLE);
    assign resp_valid   = (r_state == c_ST_REPORT);
    assign transmit     = r_transmit;
    assign tx_byte      = r_tx_byte;
    assign resp_ok      = r_resp_ok;
    assign resp_timeout = r_resp_timeout;
    assign resp_byte    = r_resp_byte;

endmodule
`default_nettype wire

// File: tb/tb_pulse_cmd_sender.sv
`default_nettype none
// ============================================================================
// Module      : tb_pulse_cmd_sender
// Description : Directed, table-driven bench for pulse_cmd_sender with a
//               small UART transmitter model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pulse_cmd_sender;

    localparam logic [31:0] c_ACK_TIMEOUT = 32'd100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_ctrl = 8'd0;
    logic [31:0] cmd_data = 32'd0;
    logic        transmit;
    logic [7:0]  tx_byte;
    logic        is_transmitting = 1'b0;
    logic        received = 1'b0;
    logic [7:0]  rx_byte = 8'd0;
    logic        recv_error = 1'b0;
    logic        resp_valid;
    logic        resp_ok;
    logic        resp_timeout;
    logic [7:0]  resp_byte;

    always #5 clk = ~clk;

    pulse_cmd_sender #(
        .ACK_TIMEOUT (c_ACK_TIMEOUT),
        .NBYTES_DATA (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_ctrl        (cmd_ctrl),
        .cmd_data        (cmd_data),
        .transmit        (transmit),
        .tx_byte         (tx_byte),
        .is_transmitting (is_transmitting),
        .received        (received),
        .rx_byte         (rx_byte),
        .recv_error      (recv_error),
        .resp_valid      (resp_valid),
        .resp_ok         (resp_ok),
        .resp_timeout    (resp_timeout),
        .resp_byte       (resp_byte)
    );

    int checks = 0;
    int failures = 0;
    int uart_len = 3;
    int busy_cnt = 0;
    int tx_while_busy = 0;
    logic [7:0] tx_log[$];

    // UART transmitter model: each strobe logs the byte and holds busy for uart_len cycles.
    always @(negedge clk) begin
        if (rst) begin
            is_transmitting = 1'b0;
            busy_cnt = 0;
        end else if (transmit) begin
            if (is_transmitting) tx_while_busy++;
            tx_log.push_back(tx_byte);
            is_transmitting = 1'b1;
            busy_cnt = uart_len;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) is_transmitting = 1'b0;
        end
    end

    typedef struct {
        logic [7:0]  ctrl;
        logic [31:0] data;
        int          mode;     // 0 = received, 1 = recv_error, 2 = both at once
        logic [7:0]  echo;
        logic [39:0] frame;    // bytes in transmit order, first byte leftmost
        logic        exp_ok;
        logic [7:0]  exp_byte;
    } vec_t;

    vec_t vecs[7];

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [39:0] got_frame();
        if (tx_log.size() != 5) return 40'd0;
        return {tx_log[0], tx_log[1], tx_log[2], tx_log[3], tx_log[4]};
    endfunction

    task automatic start_cmd(input logic [7:0] c, input logic [31:0] d);
        tx_log.delete();
        chk("cmd_ready_idle", {63'd0, cmd_ready}, 64'd1);
        cmd_ctrl  = c;
        cmd_data  = d;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        cmd_ctrl  = 8'hAA;
        cmd_data  = 32'hDEAD_BEEF;
        chk("cmd_accepted", {63'd0, cmd_ready}, 64'd0);
    endtask

    task automatic wait_sent(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            step();
            if (tx_log.size() == 5 && !is_transmitting) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_count(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (tx_log.size() >= n) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic echo(input int mode, input logic [7:0] b);
        received   = (mode != 1);
        recv_error = (mode != 0);
        rx_byte    = b;
        step();
        received   = 1'b0;
        recv_error = 1'b0;
        rx_byte    = 8'd0;
    endtask

    task automatic wait_resp(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (resp_valid) begin
                seen = 1'b1;
                break;
            end
            step();
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ok;
        bit seen;
        bit early_ready;
        int n;
        int pulses;

        vecs[0] = '{8'h00, 32'h0000_03E8, 0, 8'hEB, 40'hE8_03_00_00_00, 1'b1, 8'hEB};
        vecs[1] = '{8'h04, 32'hFFFF_FFFF, 0, 8'h12, 40'hFF_FF_FF_FF_04, 1'b0, 8'h12};
        vecs[2] = '{8'h04, 32'hFFFF_FFFF, 0, 8'hFC, 40'hFF_FF_FF_FF_04, 1'b1, 8'hFC};
        vecs[3] = '{8'h05, 32'h1234_5678, 0, 8'h14, 40'h78_56_34_12_05, 1'b1, 8'h14};
        vecs[4] = '{8'h02, 32'h8080_8080, 0, 8'h00, 40'h80_80_80_80_02, 1'b1, 8'h00};
        vecs[5] = '{8'h03, 32'h0102_0304, 1, 8'h0A, 40'h04_03_02_01_03, 1'b0, 8'h0A};
        vecs[6] = '{8'h01, 32'h0000_0001, 2, 8'h01, 40'h01_00_00_00_01, 1'b0, 8'h01};

        // Reset values.
        step();
        step();
        chk("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
        chk("rst_outputs", {44'd0, transmit, tx_byte, resp_valid, resp_ok, resp_timeout, resp_byte},
            64'd0);

        // Table vectors; the first command is issued right as reset releases.
        rst = 1'b0;
        for (int i = 0; i < 7; i++) begin
            start_cmd(vecs[i].ctrl, vecs[i].data);
            wait_sent(ok);
            chk($sformatf("v%0d_sent", i), {63'd0, ok}, 64'd1);
            chk($sformatf("v%0d_frame", i), {24'd0, got_frame()}, {24'd0, vecs[i].frame});
            step();
            echo(vecs[i].mode, vecs[i].echo);
            wait_resp(seen);
            chk($sformatf("v%0d_resp_valid", i), {63'd0, seen}, 64'd1);
            chk($sformatf("v%0d_resp_ok", i), {63'd0, resp_ok}, {63'd0, vecs[i].exp_ok});
            chk($sformatf("v%0d_resp_timeout", i), {63'd0, resp_timeout}, 64'd0);
            chk($sformatf("v%0d_resp_byte", i), {56'd0, resp_byte}, {56'd0, vecs[i].exp_byte});
            step();
            chk($sformatf("v%0d_resp_pulse", i), {62'd0, resp_valid, cmd_ready}, 64'd1);
            chk($sformatf("v%0d_byte_held", i), {56'd0, resp_byte}, {56'd0, vecs[i].exp_byte});
        end

        // Slow UART, spurious strobes mid-frame, then no echo at all.
        uart_len = 50;
        tx_while_busy = 0;
        start_cmd(8'h00, 32'h0000_03E8);
        wait_count(2, ok);
        received = 1'b1;
        rx_byte  = 8'hEB;
        step();
        received   = 1'b0;
        recv_error = 1'b1;
        step();
        recv_error = 1'b0;
        rx_byte    = 8'd0;
        chk("spurious_no_resp", {63'd0, resp_valid}, 64'd0);
        wait_sent(ok);
        chk("slow_sent", {63'd0, ok}, 64'd1);
        chk("slow_frame", {24'd0, got_frame()}, {24'd0, 40'hE8_03_00_00_00});
        chk("no_tx_while_busy", tx_while_busy, 0);
        // First step lands after the WAIT_ACK entry edge, so resp_valid shows at step 101.
        n = 0;
        for (int i = 0; i < 300; i++) begin
            step();
            n++;
            if (resp_valid) break;
        end
        chk("timeout_latency", n, 101);
        chk("timeout_flags", {62'd0, resp_timeout, resp_ok}, 64'd2);
        chk("timeout_byte", {56'd0, resp_byte}, 64'd0);
        step();

        // A byte arriving on the timeout cycle wins.
        uart_len = 3;
        start_cmd(8'h05, 32'h0101_0101);
        wait_sent(ok);
        chk("edge_sent", {63'd0, ok}, 64'd1);
        repeat (100) step();
        chk("edge_no_early_resp", {63'd0, resp_valid}, 64'd0);
        echo(0, 8'h04);
        chk("edge_resp_valid", {63'd0, resp_valid}, 64'd1);
        chk("edge_flags", {62'd0, resp_timeout, resp_ok}, 64'd1);
        chk("edge_byte", {56'd0, resp_byte}, 64'h04);
        step();

        // Reset during byte 2 abandons the frame.
        uart_len = 50;
        start_cmd(8'h04, 32'h1122_3344);
        wait_count(3, ok);
        chk("rst_mid_reached", {63'd0, ok}, 64'd1);
        rst = 1'b1;
        step();
        chk("rst_mid_outputs", {44'd0, transmit, tx_byte, resp_valid, resp_ok, resp_timeout, resp_byte},
            64'd0);
        chk("rst_mid_ready", {63'd0, cmd_ready}, 64'd1);
        step();
        rst = 1'b0;
        pulses = tx_log.size();
        repeat (150) step();
        chk("rst_no_more_tx", tx_log.size(), pulses);
        uart_len = 3;
        start_cmd(8'h01, 32'h0000_000F);
        wait_sent(ok);
        chk("post_rst_frame", {24'd0, got_frame()}, {24'd0, 40'h0F_00_00_00_01});
        step();
        echo(0, 8'h0F);
        chk("post_rst_ok", {61'd0, resp_valid, resp_ok, resp_timeout}, 64'd6);
        step();

        // cmd_valid held high with changing inputs: only the latched frame goes out.
        tx_log.delete();
        cmd_ctrl  = 8'h02;
        cmd_data  = 32'h0A0B_0C0D;
        cmd_valid = 1'b1;
        step();
        early_ready = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            cmd_data = $urandom;
            cmd_ctrl = 8'($urandom);
            step();
            if (cmd_ready) early_ready = 1'b1;
            if (tx_log.size() == 5 && !is_transmitting) begin
                ok = 1'b1;
                break;
            end
        end
        chk("hold_sent", {63'd0, ok}, 64'd1);
        chk("hold_no_ready", {63'd0, early_ready}, 64'd0);
        chk("hold_frame", {24'd0, got_frame()}, {24'd0, 40'h0D_0C_0B_0A_02});
        step();
        echo(0, 8'h2E);
        chk("hold_resp", {61'd0, resp_valid, resp_ok, cmd_ready}, 64'd6);
        tx_log.delete();
        cmd_ctrl = 8'h03;
        cmd_data = 32'h0000_0100;
        step();
        chk("hold_ready_after", {63'd0, cmd_ready}, 64'd1);
        step();
        cmd_valid = 1'b0;
        chk("hold_second_accept", {63'd0, cmd_ready}, 64'd0);
        wait_sent(ok);
        chk("hold_second_frame", {24'd0, got_frame()}, {24'd0, 40'h00_01_00_00_03});
        step();
        echo(0, 8'h01);
        chk("hold_second_ok", {61'd0, resp_valid, resp_ok, resp_timeout}, 64'd6);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
